// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver with shadow-latched
// data, a free-running scan prescaler and a dark guard interval after each digit change.

module seg_scan_driver #(
    parameter int SCAN_BITS = 16,
    parameter int GUARD     = 4
) (
    input  logic        mainClock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    output logic [3:0]  anode,
    output logic [7:0]  segment
);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [SCAN_BITS-1:0] CNT_ZERO   = {SCAN_BITS{1'b0}};
    localparam logic [SCAN_BITS-1:0] CNT_ONE    = {{(SCAN_BITS-1){1'b0}}, 1'b1};
    localparam logic [SCAN_BITS-1:0] GUARD_LAST = SCAN_BITS'(GUARD - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] font_f(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] nibble_f(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            2'd3:    n = v[15:12];
            default: n = 4'h0;
        endcase
        return n;
    endfunction

    logic [SCAN_BITS-1:0] prescaler_q, prescaler_d;
    logic [SCAN_BITS-1:0] guard_cnt_q, guard_cnt_d;
    logic [1:0]           idx_q, idx_d;
    state_t               state_q, state_d;
    logic [15:0]          shadow_value_q, shadow_value_d;
    logic [3:0]           shadow_blank_q, shadow_blank_d;
    logic [3:0]           shadow_dp_q, shadow_dp_d;
    logic [3:0]           anode_q, anode_d;
    logic [7:0]           segment_q, segment_d;
    logic                 tick_s;
    logic                 blank_sel_s;

    assign tick_s  = &prescaler_q;
    assign anode   = anode_q;
    assign segment = segment_q;

    // Prescaler advance and shadow capture.
    always_comb begin
        prescaler_d    = prescaler_q + CNT_ONE;
        shadow_value_d = shadow_value_q;
        shadow_blank_d = shadow_blank_q;
        shadow_dp_d    = shadow_dp_q;
        if (load) begin
            shadow_value_d = value;
            shadow_blank_d = blank;
            shadow_dp_d    = dp;
        end else begin
            shadow_value_d = shadow_value_q;
            shadow_blank_d = shadow_blank_q;
            shadow_dp_d    = shadow_dp_q;
        end
    end

    // Scan FSM: a tick always restarts the guard interval on the next digit.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        guard_cnt_d = guard_cnt_q;
        if (tick_s) begin
            idx_d       = idx_q + 2'd1;
            state_d     = ST_GUARD;
            guard_cnt_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_GUARD: begin
                    if (guard_cnt_q == GUARD_LAST) begin
                        state_d     = ST_SHOW;
                        guard_cnt_d = CNT_ZERO;
                    end else begin
                        guard_cnt_d = guard_cnt_q + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    state_d = ST_SHOW;
                end
                default: begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Pin drive from the post-edge digit; segments follow even while dark so they settle in guard.
    always_comb begin
        blank_sel_s = shadow_blank_q[idx_d];
        anode_d     = 4'b1111;
        segment_d   = 8'hFF;
        if ((state_d == ST_SHOW) && !blank_sel_s) begin
            anode_d = ~(4'b0001 << idx_d);
        end else begin
            anode_d = 4'b1111;
        end
        if (blank_sel_s) begin
            segment_d = 8'hFF;
        end else begin
            segment_d = {~shadow_dp_q[idx_d], font_f(nibble_f(shadow_value_q, idx_d))};
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge mainClock) begin
        if (reset) begin
            prescaler_q    <= CNT_ZERO;
            guard_cnt_q    <= CNT_ZERO;
            idx_q          <= 2'd0;
            state_q        <= ST_GUARD;
            shadow_value_q <= 16'h0000;
            shadow_blank_q <= 4'b0000;
            shadow_dp_q    <= 4'b0000;
            anode_q        <= 4'b1111;
            segment_q      <= 8'hFF;
        end else begin
            prescaler_q    <= prescaler_d;
            guard_cnt_q    <= guard_cnt_d;
            idx_q          <= idx_d;
            state_q        <= state_d;
            shadow_value_q <= shadow_value_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_dp_q    <= shadow_dp_d;
            anode_q        <= anode_d;
            segment_q      <= segment_d;
        end
    end

    seg_scan_driver_chk u_chk (
        .mainClock (mainClock),
        .reset     (reset),
        .anode     (anode),
        .segment   (segment)
    );

endmodule

// Output invariants: never two digits driven at once, and a clean state after reset.
module seg_scan_driver_chk (
    input logic       mainClock,
    input logic       reset,
    input logic [3:0] anode,
    input logic [7:0] segment
);

    a_one_anode: assert property (@(posedge mainClock) disable iff (reset)
        $onehot0(~anode));

    a_reset_dark: assert property (@(posedge mainClock) disable iff (reset)
        $past(reset) |-> ((anode == 4'b1111) && (segment == 8'hFF)));

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a frame-position model plus directed literal checks.

module tb_seg_scan_driver;

    localparam int SB     = 4;
    localparam int GD     = 2;
    localparam int PERIOD = 1 << SB;

    logic        mainClock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  anode;
    logic [7:0]  segment;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.SCAN_BITS(SB), .GUARD(GD)) dut (
        .mainClock (mainClock),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .blank     (blank),
        .dp        (dp),
        .anode     (anode),
        .segment   (segment)
    );

    always #5 mainClock = ~mainClock;

    logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Expected pins t edges after reset, from frame position alone.
    function automatic logic [3:0] m_anode(input int t, input logic [3:0] bl);
        int digit;
        int phase;
        digit = (t / PERIOD) % 4;
        phase = t % PERIOD;
        if (phase >= GD && !bl[digit]) return ~(4'b0001 << digit);
        return 4'b1111;
    endfunction

    function automatic logic [7:0] m_seg(input int t, input logic [15:0] v,
                                         input logic [3:0] bl, input logic [3:0] d);
        int digit;
        logic [3:0] nib;
        digit = (t / PERIOD) % 4;
        nib   = v[digit*4 +: 4];
        if (bl[digit]) return 8'hFF;
        return {~d[digit], font_tab[nib]};
    endfunction

    int          k = 0;
    logic [15:0] sh_val = 16'h0;
    logic [3:0]  sh_blank = 4'h0;
    logic [3:0]  sh_dp = 4'h0;
    logic [3:0]  exp_anode = 4'hF;
    logic [7:0]  exp_seg = 8'hFF;
    bit          model_valid = 1'b0;

    always @(posedge mainClock) begin
        if (reset) begin
            k           <= 0;
            sh_val      <= 16'h0;
            sh_blank    <= 4'h0;
            sh_dp       <= 4'h0;
            exp_anode   <= 4'hF;
            exp_seg     <= 8'hFF;
            model_valid <= 1'b1;
        end else begin
            k         <= k + 1;
            exp_anode <= m_anode(k + 1, sh_blank);
            exp_seg   <= m_seg(k + 1, sh_val, sh_blank, sh_dp);
            if (load) begin
                sh_val   <= value;
                sh_blank <= blank;
                sh_dp    <= dp;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
        end
    endtask

    bit win_en  = 1'b0;
    int lit_run = 0;

    task automatic check_cycle();
        if (model_valid) begin
            chk("model_anode", 32'(anode), 32'(exp_anode));
            chk("model_segment", 32'(segment), 32'(exp_seg));
            chk("one_anode_low", 32'($countones(~anode) <= 1), 32'd1);
            if (anode != 4'b1111) begin
                lit_run++;
            end else begin
                if (lit_run > 0 && win_en) chk("lit_window_len", 32'(lit_run), 32'(PERIOD - GD));
                lit_run = 0;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge mainClock);
            check_cycle();
        end
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [7:0] s);
        chk({name, "_anode"}, 32'(anode), 32'(a));
        chk({name, "_segment"}, 32'(segment), 32'(s));
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        blank = 4'b0000;
        dp    = 4'b0000;
        cyc(3);
        lit("reset", 4'b1111, 8'hFF);
        reset  = 1'b0;
        win_en = 1'b1;
        cyc(1);  chk("rel_e1_anode", 32'(anode), 32'h0F);
        cyc(1);  lit("rel_e2", 4'b1110, 8'hC0);
        cyc(13); chk("rel_e15_anode", 32'(anode), 32'h0E);
        cyc(2);  chk("rel_e17_anode", 32'(anode), 32'h0F);
        cyc(1);  lit("rel_e18", 4'b1101, 8'hC0);

        load = 1'b1; value = 16'h1A8F; dp = 4'b0100; blank = 4'b0000;
        cyc(1);  load = 1'b0; chk("load_lat_old", 32'(segment), 32'hC0);
        cyc(1);  chk("load_lat_new", 32'(segment), 32'h80);
        cyc(14); lit("dig2", 4'b1011, 8'h08);
        cyc(16); lit("dig3", 4'b0111, 8'hF9);
        cyc(16); lit("dig0", 4'b1110, 8'h8E);

        load = 1'b1; blank = 4'b1010;
        cyc(1);  load = 1'b0;
        cyc(15); lit("blank_d1", 4'b1111, 8'hFF);
        cyc(16); lit("blank_d2", 4'b1011, 8'h08);
        cyc(16); lit("blank_d3", 4'b1111, 8'hFF);
        cyc(16); lit("blank_d0", 4'b1110, 8'h8E);
        load = 1'b1; blank = 4'b0000;
        cyc(1);  load = 1'b0;

        cyc(12);
        load = 1'b1; value = 16'h5E3C; dp = 4'b0000;
        cyc(1);  load = 1'b0; lit("tickload_e0", 4'b1111, 8'h80);
        cyc(1);  chk("tickload_e1_segment", 32'(segment), 32'hB0);
        cyc(1);  lit("tickload_e2", 4'b1101, 8'hB0);
        cyc(24); lit("pre_reset_d2", 4'b1011, 8'h86);

        win_en = 1'b0;
        reset  = 1'b1;
        cyc(1);  lit("mid_reset", 4'b1111, 8'hFF);
        reset = 1'b0;
        cyc(1);  chk("rerel_e1_anode", 32'(anode), 32'h0F);
        cyc(1);  lit("rerel_e2", 4'b1110, 8'hC0);
        win_en = 1'b1;
        cyc(14); chk("rerel_e16_anode", 32'(anode), 32'h0F);

        for (int i = 0; i < 1000; i++) begin
            if ((i % 37) == 5 || (i >= 600 && i < 604)) begin
                load  = 1'b1;
                value = 16'($urandom);
                dp    = 4'($urandom);
            end else begin
                load = 1'b0;
            end
            cyc(1);
        end
        load = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Display-side consumer for the board's 4-bit counters: latches a 16-bit value (four hex nibbles) on a load strobe and drives a 4-digit, common-anode, multiplexed seven-segment display. A free-running prescaler on mainClock sets the digit scan rate. A guard interval blanks all anodes after each digit change to prevent ghosting. Sits between the counter logic and the board's anode/segment pins.

## Interface
- SCAN_BITS, 16: prescaler width; one digit period = 2^SCAN_BITS cycles.
- GUARD, 4: all-anodes-off cycles at the start of each digit period; legal range 1 to 2^SCAN_BITS − 1.

- mainClock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- load  in  1  when high at an edge, latch value/blank/dp into shadow registers.
- value  in  16  digit i = value[4i+3:4i]; digit 0 = rightmost.
- blank  in  4  blank[i]=1 keeps digit i dark.
- dp  in  4  dp[i]=1 lights the decimal point of digit i.
- anode  out  4  active-low digit enables; at most one bit low at any time.
- segment  out  8  active-low {dp,g,f,e,d,c,b,a}.

## Operation
- Reset values:
  - prescaler = 0, idx = 0, state = GUARD, guardCnt = 0.
  - shadowValue = 16'h0000, shadowBlank = 4'b0000, shadowDp = 4'b0000.
  - anode = 4'b1111, segment = 8'hFF.
- Prescaler: increments every non-reset edge and wraps. tick = &prescaler, combinational.
- Shadow registers: load only when load=1 and reset=0. They hold otherwise.
- State machine (two states):
  - GUARD: guardCnt increments each edge. At the edge where guardCnt == GUARD−1: go to SHOW, guardCnt ← 0.
  - SHOW: hold until tick.
  - From either state, tick at an edge: idx ← idx+1 (mod 4), state ← GUARD, guardCnt ← 0. Tick takes priority over the GUARD exit.
- anode (registered, reflects state after the edge):
  - GUARD → 4'b1111.
  - SHOW → ~(4'b0001 << idx). If shadowBlank[idx]=1, 4'b1111 instead.
- segment (registered, updated every edge from post-edge idx and current shadow contents):
  - If shadowBlank[idx]: 8'hFF.
  - Else: {~shadowDp[idx], font(nibble)}.
- font, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Segments settle during GUARD, so the lit digit never shows the previous digit's pattern.

## Timing
- Reset release: GUARD is held for the first GUARD edges. After edge GUARD, anode = 4'b1110. First tick occurs at edge 2^SCAN_BITS, i.e. when prescaler == all-ones before that edge.
- Digit period: exactly 2^SCAN_BITS cycles, of which GUARD are dark and 2^SCAN_BITS − GUARD are lit. Full frame = 4·2^SCAN_BITS cycles.
- Load latency: shadow updates at edge N. segment reflects the new data after edge N+1.
- load and tick at the same edge: both take effect; the next segment uses the new shadow with the new idx.
- load held high: re-latches every edge; last value wins.
- Reset asserted mid-frame: all registers return to reset values at that edge. load is ignored while reset=1.
- idx wrap: 3 → 0 with no extra dark cycles beyond GUARD.

## Test plan
- Bench parameters SCAN_BITS=4, GUARD=2.
- Reset release, no load:
  - anode = 1111 for 2 cycles, then 1110 for 14 cycles, then 1111 for 2 cycles, then 1101.
  - segment = C0 while digit 0 is lit.
- load value=16'h1A8F, dp=4'b0100:
  - Digit 0 lit → segment 8E.
  - Digit 1 → 80.
  - Digit 2 → 08 (dp lit).
  - Digit 3 → F9.
  - Anode sequence 1110, 1101, 1011, 0111, repeating every 64 cycles.
- blank=4'b1010: anode stays 1111 during the digit-1 and digit-3 periods, and segment = FF there. Digits 0 and 2 behave normally.
- Load pulse on the same edge as a tick:
  - idx advances.
  - The new nibble appears on segment one edge later.
  - Never more than one anode bit low.
- Reset pulse mid-SHOW of digit 2:
  - Next cycle anode = 1111, segment = FF, shadow cleared.
  - The sequence restarts exactly as after power-up.
- Continuous check over 1000 cycles:
  - popcount(~anode) ≤ 1 at every cycle.
  - Each lit window is exactly 14 cycles.
